ln_row_fifo: RTL and testbench

Store-and-forward row buffer between the butterfly engine output and `layer_norm`. Accepts beats of `p_ln` fp16 lanes, groups them into rows of `length` elements, and releases a row downstream only after its final beat is stored. `layer_norm` therefore always receives each row as a gap-free burst with an explicit end-of-row marker, whatever the upstream stall pattern.

---
 rtl/ln_row_fifo.sv | 158 +++++++++++++++
 tb/tb_ln_row_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ln_row_fifo.sv
// ln_row_fifo: store-and-forward row buffer in front of layer_norm.
// Beats are grouped into rows of length/p_ln beats. A row becomes visible
// downstream only once its final beat is stored, so each row leaves as a
// gap-free burst terminated by dn_last.
module ln_row_fifo #(
  parameter int unsigned data_width = 16,
  parameter int unsigned p_ln       = 8,
  parameter int unsigned depth      = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         up_vld,
  input  logic [data_width*p_ln-1:0]   up_dat,
  output logic                         up_rdy,
  input  logic [15:0]                  length,
  output logic                         dn_vld,
  output logic [data_width*p_ln-1:0]   dn_dat,
  output logic                         dn_last,
  input  logic                         dn_rdy,
  output logic                         err_len
);

  localparam int unsigned dat_w = data_width * p_ln;
  localparam int unsigned ent_w = dat_w + 1;
  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = ptr_w + 1;

  // storage: {last, data} per entry
  logic [ent_w-1:0] r_mem [depth];

  logic [ptr_w-1:0] r_wr_ptr;
  logic [ptr_w-1:0] r_rd_ptr;
  logic [cnt_w-1:0] r_used;
  logic [cnt_w-1:0] r_avail;
  logic [cnt_w-1:0] r_wcnt;
  logic [cnt_w-1:0] r_bpr;
  logic             r_err;
  logic             r_up_rdy;
  logic             r_dn_vld;

  logic [15:0]      w_len_bpr;
  logic [15:0]      w_len_rem;
  logic             w_len_ok;
  logic             w_first;
  logic [cnt_w-1:0] w_bpr_row;
  logic             w_wr_hs;
  logic             w_drop;
  logic             w_wr;
  logic             w_row_end;
  logic             w_commit;
  logic             w_rd;
  logic             w_err_nxt;
  logic [cnt_w-1:0] w_used_nxt;
  logic [cnt_w-1:0] w_avail_nxt;
  logic [ptr_w-1:0] w_wr_ptr_nxt;
  logic [ptr_w-1:0] w_rd_ptr_nxt;
  logic [cnt_w-1:0] w_wcnt_nxt;
  logic [cnt_w-1:0] w_bpr_nxt;
  logic [ent_w-1:0] w_head;

  // length legality, judged only when a row's first beat is offered
  always_comb begin
    w_len_bpr = length / 16'(p_ln);
    w_len_rem = length % 16'(p_ln);
    w_len_ok  = (length != 16'd0) && (w_len_rem == 16'd0) &&
                (w_len_bpr <= 16'(depth));
  end

  // handshake decode, row tracking and next-state for all counters
  always_comb begin
    w_first      = (r_wcnt == '0);
    w_bpr_row    = w_first ? cnt_w'(w_len_bpr) : r_bpr;
    w_wr_hs      = up_vld && r_up_rdy;
    w_drop       = w_wr_hs && w_first && !w_len_ok;
    w_wr         = w_wr_hs && !w_drop;
    w_row_end    = (r_wcnt == (w_bpr_row - cnt_w'(1)));
    w_commit     = w_wr && w_row_end;
    w_rd         = r_dn_vld && dn_rdy;
    w_err_nxt    = r_err || w_drop;

    w_used_nxt   = r_used;
    w_avail_nxt  = r_avail;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_wcnt_nxt   = r_wcnt;
    w_bpr_nxt    = r_bpr;

    if (w_wr && !w_rd) begin
      w_used_nxt = r_used + cnt_w'(1);
    end else if (!w_wr && w_rd) begin
      w_used_nxt = r_used - cnt_w'(1);
    end

    if (w_commit) begin
      w_avail_nxt = w_avail_nxt + w_bpr_row;
    end
    if (w_rd) begin
      w_avail_nxt  = w_avail_nxt - cnt_w'(1);
      w_rd_ptr_nxt = r_rd_ptr + ptr_w'(1);
    end

    if (w_wr) begin
      w_wr_ptr_nxt = r_wr_ptr + ptr_w'(1);
      w_wcnt_nxt   = w_row_end ? '0 : (r_wcnt + cnt_w'(1));
      if (w_first) begin
        w_bpr_nxt = w_bpr_row;
      end
    end
  end

  // control state registers; ready/valid registered from next-state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
      r_avail  <= '0;
      r_wcnt   <= '0;
      r_bpr    <= '0;
      r_err    <= 1'b0;
      r_up_rdy <= 1'b0;
      r_dn_vld <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_used   <= w_used_nxt;
      r_avail  <= w_avail_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_bpr    <= w_bpr_nxt;
      r_err    <= w_err_nxt;
      r_up_rdy <= !w_err_nxt && (w_used_nxt != cnt_w'(depth));
      r_dn_vld <= (w_avail_nxt != '0);
    end
  end

  // beat storage; cleared on reset so the head reads as zero when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_row_end, up_dat};
    end
  end

  // head entry presented combinationally
  always_comb begin
    w_head = r_mem[r_rd_ptr];
  end

  assign up_rdy  = r_up_rdy;
  assign dn_vld  = r_dn_vld;
  assign dn_dat  = w_head[dat_w-1:0];
  assign dn_last = w_head[dat_w];
  assign err_len = r_err;

endmodule

// File: tb/tb_ln_row_fifo.sv
// Bench for ln_row_fifo: randomized rows checked by a queue-based row model.
module tb_ln_row_fifo;

  localparam int DW  = 16;
  localparam int P   = 8;
  localparam int D   = 64;
  localparam int DAT = DW * P;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           up_vld = 1'b0;
  logic [DAT-1:0] up_dat = '0;
  logic           up_rdy;
  logic [15:0]    length = 16'd256;
  logic           dn_vld;
  logic [DAT-1:0] dn_dat;
  logic           dn_last;
  logic           dn_rdy = 1'b0;
  logic           err_len;

  int total = 0;
  int bad   = 0;

  // reference model: beats of the row being written, committed beats awaiting read
  logic [DAT-1:0] row_q[$];
  logic [DAT:0]   exp_q[$];
  int             m_bpr = 0;
  bit             m_err = 1'b0;
  bit             m_armed = 1'b0;
  bit             rand_dn = 1'b0;

  ln_row_fifo #(.data_width(DW), .p_ln(P), .depth(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .up_vld  (up_vld),
    .up_dat  (up_dat),
    .up_rdy  (up_rdy),
    .length  (length),
    .dn_vld  (dn_vld),
    .dn_dat  (dn_dat),
    .dn_last (dn_last),
    .dn_rdy  (dn_rdy),
    .err_len (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DAT:0] act, input logic [DAT:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare against the model, then apply the transfers of the coming edge
  always @(negedge clk) begin
    bit rd;
    bit wr;
    logic lst;
    if (rst) begin
      row_q.delete();
      exp_q.delete();
      m_err   = 1'b0;
      m_armed = 1'b0;
    end else begin
      chk("dn_vld", DAT'(dn_vld), DAT'(exp_q.size() != 0));
      chk("up_rdy", DAT'(up_rdy),
          DAT'(m_armed && !m_err && (row_q.size() + exp_q.size() != D)));
      chk("err_len", DAT'(err_len), DAT'(m_err));
      if (dn_vld && exp_q.size() != 0) chk("dn_beat", {dn_last, dn_dat}, exp_q[0]);
      rd = dn_vld && dn_rdy;
      wr = up_vld && up_rdy;
      if (rd && exp_q.size() != 0) void'(exp_q.pop_front());
      if (wr) begin
        if (row_q.size() == 0 &&
            (length == 0 || (int'(length) % P) != 0 || (int'(length) / P) > D)) begin
          m_err = 1'b1;
        end else begin
          if (row_q.size() == 0) m_bpr = int'(length) / P;
          row_q.push_back(up_dat);
          if (row_q.size() == m_bpr) begin
            for (int i = 0; i < m_bpr; i++) begin
              lst = (i == m_bpr - 1);
              exp_q.push_back({lst, row_q[i]});
            end
            row_q.delete();
          end
        end
      end
      m_armed = 1'b1;
    end
  end

  // random downstream back-pressure when enabled
  always @(posedge clk) begin
    if (rand_dn) begin
      #1;
      dn_rdy = ($urandom % 3) != 0;
    end
  end

  task automatic send(input logic [DAT-1:0] d);
    int n;
    n = 0;
    up_vld = 1'b1;
    up_dat = d;
    forever begin
      @(negedge clk);
      if (up_rdy) break;
      n++;
      if (n > 3000) begin
        total++;
        bad++;
        $display("FAIL send_timeout: up_rdy stuck 0 at %0t", $time);
        break;
      end
    end
    @(posedge clk);
    #1;
    up_vld = 1'b0;
  endtask

  function automatic logic [DAT-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send(rnd_beat());
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    dn_rdy = 1'b1;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
  endtask

  task automatic reset_checks();
    chk("rst_dn_vld", DAT'(dn_vld), '0);
    chk("rst_up_rdy", DAT'(up_rdy), '0);
    chk("rst_err_len", DAT'(err_len), '0);
    chk("rst_head", {dn_last, dn_dat}, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    up_vld = 1'b0;
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // one 32-beat row, continuous, downstream always ready
    length = 16'd256;
    dn_rdy = 1'b1;
    send_beats(32, 0);
    drain();

    // 8-beat row with upstream idling every other cycle
    length = 16'd64;
    send_beats(8, 1);
    drain();

    // fill to full with downstream stalled, then drain and refill across wrap
    length = 16'd256;
    dn_rdy = 1'b0;
    fork
      send_beats(96, 0);
      begin
        repeat (100) @(posedge clk);
        #1;
        dn_rdy = 1'b1;
      end
    join
    drain();

    // row B commits in the same cycle row A's last beat is read
    length = 16'd64;
    dn_rdy = 1'b1;
    send_beats(16, 0);
    drain();

    // reset in the middle of draining a committed row
    dn_rdy = 1'b0;
    send_beats(8, 0);
    @(posedge clk);
    #1;
    dn_rdy = 1'b1;
    do_reset();

    // reset after 5 beats of a 32-beat row, then a clean row
    length = 16'd256;
    send_beats(5, 0);
    do_reset();
    send_beats(32, 0);
    drain();

    // randomized rows, lengths from one beat up to full depth
    rand_dn = 1'b1;
    for (int r = 0; r < 14; r++) begin
      case (r % 4)
        0: length = 16'd8;
        1: length = 16'(P * D);
        default: length = 16'(P * $urandom_range(1, 20));
      endcase
      send_beats(int'(length) / P, int'($urandom % 2));
    end
    rand_dn = 1'b0;
    @(posedge clk);
    #1;
    drain();

    // illegal length (not a lane multiple) after a committed row
    dn_rdy = 1'b0;
    length = 16'd64;
    send_beats(8, 0);
    length = 16'd12;
    send_beats(1, 0);
    repeat (4) @(posedge clk);
    #1;
    drain();
    repeat (3) @(posedge clk);
    do_reset();

    // illegal length: more beats than depth, then zero length
    length = 16'(P * (D + 1));
    send_beats(1, 0);
    repeat (3) @(posedge clk);
    do_reset();
    length = 16'd0;
    send_beats(1, 0);
    repeat (3) @(posedge clk);
    do_reset();

    // a legal row after the error resets
    length = 16'd64;
    send_beats(8, 0);
    drain();
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
